// File: rtl/adc_capture_ctrl.sv
// Serial-ADC front end: generates adc_clk/adc_conv, shifts in a frame, extracts a
// sample field, decimates, applies a level/edge trigger and hands samples over valid/ready.
module adc_capture_ctrl #(
  parameter int CLK_DIV    = 64,
  parameter int FRAME_BITS = 16,
  parameter int MSB_POS    = 13,
  parameter int SAMPLE_W   = 8,
  parameter int CONV_IDLE  = 3,
  parameter int DEC_W      = 8
) (
  input  logic                osc_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [1:0]          trig_mode,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [DEC_W-1:0]    decim,
  input  logic                adc_data,
  output logic                adc_clk,
  output logic                adc_conv,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                armed,
  output logic                triggered,
  output logic                overrun
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int DIV_W   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int CNT_MAX = (FRAME_BITS > CONV_IDLE) ? FRAME_BITS : CONV_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DEC_W-1:0]      dec_cnt;
  logic                  rise_stb;
  logic [FRAME_BITS-1:0] frame_p0;
  logic [SAMPLE_W-1:0]   cur_p0;
  logic                  done_p0, keep_p0, fire_p0, pass_p0;
  logic [SAMPLE_W-1:0]   prev_sample;
  logic                  prev_valid;
  logic [SAMPLE_W-1:0]   sample_p1;
  logic                  vld_p1;
  logic                  load_ok;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_cnt == DIV_W'(HALF - 1)) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign rise_stb = enable && !adc_clk && (div_cnt == DIV_W'(HALF - 1));

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_CONV;
        S_CONV:  if (rise_stb && bit_cnt == CNT_W'(CONV_IDLE - 1)) state_nxt = S_SHIFT;
        S_SHIFT: if (rise_stb && bit_cnt == CNT_W'(FRAME_BITS - 1)) state_nxt = S_DONE;
        default: state_nxt = S_CONV;
      endcase
    end
  end

  always_comb begin
    adc_conv = (state != S_SHIFT);
    done_p0  = enable && (state == S_DONE);
    armed    = enable && (state != S_IDLE) && !triggered;
  end

  // Counts CONV periods, then frame bits; restarts on every state change.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset)                                begin bit_cnt <= '0; end
    else if (!enable || state_nxt != state)   begin bit_cnt <= '0; end
    else if (rise_stb && (state == S_CONV || state == S_SHIFT)) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge osc_clk) begin
    if (state == S_SHIFT && rise_stb) frame_p0 <= {frame_p0[FRAME_BITS-2:0], adc_data};
  end

  // ---- p0: frame complete, extract / decimate / trigger ----
  assign cur_p0  = frame_p0[MSB_POS -: SAMPLE_W];
  assign keep_p0 = done_p0 && (dec_cnt == '0);

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset)        dec_cnt <= '0;
    else if (done_p0) dec_cnt <= keep_p0 ? decim : dec_cnt - DEC_W'(1);
  end

  always_comb begin
    case (trig_mode)
      2'b01:   fire_p0 = prev_valid && (prev_sample <  trig_level) && (cur_p0 >= trig_level);
      2'b10:   fire_p0 = prev_valid && (prev_sample >= trig_level) && (cur_p0 <  trig_level);
      default: fire_p0 = 1'b1;
    endcase
  end

  assign pass_p0 = keep_p0 && !clear && (triggered || fire_p0);

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      triggered  <= 1'b0;
      prev_valid <= 1'b0;
    end else if (!enable || clear) begin
      triggered  <= 1'b0;
      prev_valid <= 1'b0;
    end else if (keep_p0) begin
      prev_valid <= 1'b1;
      if (fire_p0) triggered <= 1'b1;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (keep_p0) prev_sample <= cur_p0;
  end

  // ---- p1: single-entry output register ----
  assign load_ok = !vld_p1 || sample_ready;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (pass_p0 && load_ok) begin
        sample_p1 <= cur_p0;
        vld_p1    <= 1'b1;
      end else if (vld_p1 && sample_ready) begin
        vld_p1    <= 1'b0;
      end
      if (clear)                    overrun <= 1'b0;
      else if (pass_p0 && !load_ok) overrun <= 1'b1;
    end
  end

  assign sample_data  = sample_p1;
  assign sample_valid = vld_p1;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a behavioural serial-ADC model and a
// transfer monitor; CLK_DIV=4 gives a 76-cycle frame period.
module tb_adc_capture_ctrl;

  logic       osc_clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] trig_mode = 2'b00;
  logic [7:0] trig_level = 8'h00;
  logic [7:0] decim = 8'h00;
  logic       adc_data = 1'b0;
  logic       adc_clk, adc_conv;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b1;
  logic       armed, triggered, overrun;

  adc_capture_ctrl #(
    .CLK_DIV(4), .FRAME_BITS(16), .MSB_POS(13), .SAMPLE_W(8), .CONV_IDLE(3), .DEC_W(8)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .enable(enable), .clear(clear),
    .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim),
    .adc_data(adc_data), .adc_clk(adc_clk), .adc_conv(adc_conv),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .armed(armed), .triggered(triggered), .overrun(overrun)
  );

  always #5 osc_clk = ~osc_clk;

  int cyc = 0;
  always @(posedge osc_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: new frame on adc_conv fall, next bit on each adc_clk fall.
  logic [15:0] frames [0:7];
  logic [15:0] cur_frame = 16'h0;
  int fidx = 0;
  int bidx = -1;

  always @(negedge adc_conv) begin
    cur_frame = frames[fidx % 8];
    fidx++;
    bidx = 15;
  end

  always @(negedge adc_clk) begin
    if (!adc_conv && bidx >= 0) begin
      adc_data = cur_frame[bidx];
      bidx--;
    end
  end

  // Transfer monitor and timing probes, sampled mid-cycle.
  logic [7:0] xq_data[$];
  int xq_cyc[$];
  int rise_cyc = 0, lat_last = 0, conv_low = 0, conv_low_last = 0;
  logic clk_d = 1'b0, vld_d = 1'b0;

  always @(negedge osc_clk) begin
    if (!reset) begin
      if (sample_valid && sample_ready) begin
        xq_data.push_back(sample_data);
        xq_cyc.push_back(cyc);
      end
      if (adc_clk && !clk_d) rise_cyc = cyc;
      if (sample_valid && !vld_d) lat_last = cyc - (rise_cyc - 1);
      if (!adc_conv) conv_low++;
      else if (conv_low > 0) begin
        conv_low_last = conv_low;
        conv_low = 0;
      end
    end
    clk_d = adc_clk;
    vld_d = sample_valid;
  end

  function automatic logic [15:0] mk(input logic [7:0] x);
    return {2'b10, x, 6'b010101};
  endfunction

  function automatic logic [31:0] xd(input int i);
    return (i < xq_data.size()) ? 32'(xq_data[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic int xc(input int i);
    return (i < xq_cyc.size()) ? xq_cyc[i] : -100000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    sample_ready = 1'b1;
    trig_mode = 2'b00;
    trig_level = 8'h00;
    decim = 8'h00;
    step(3);
    fidx = 0;
    conv_low = 0;
    conv_low_last = 0;
    xq_data.delete();
    xq_cyc.delete();
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k = 0;
    while (xq_data.size() < n && k < budget) begin
      @(posedge osc_clk);
      k++;
    end
    #1;
    check_eq(tag, 32'(xq_data.size() >= n), 32'd1);
  endtask

  task automatic start(output int c0);
    enable = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    int c0;
    int c1;

    // reset state
    step(2);
    check_eq("rst_adc_clk", adc_clk, 0);
    check_eq("rst_adc_conv", adc_conv, 1);
    check_eq("rst_data", sample_data, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_armed", armed, 0);
    check_eq("rst_trig", triggered, 0);
    check_eq("rst_ovr", overrun, 0);

    // free-run, frame 2A5C -> A9 every 76 cycles
    for (int i = 0; i < 8; i++) frames[i] = 16'h2A5C;
    do_reset();
    start(c0);
    wait_xfers("fr_timeout", 3, 300);
    check_eq("fr_d0", xd(0), 32'hA9);
    check_eq("fr_d1", xd(1), 32'hA9);
    check_eq("fr_d2", xd(2), 32'hA9);
    check_eq("fr_first_lat", 32'(xc(0) - c0), 32'd75);
    check_eq("fr_period1", 32'(xc(1) - xc(0)), 32'd76);
    check_eq("fr_period2", 32'(xc(2) - xc(1)), 32'd76);
    check_eq("fr_lastbit_lat", 32'(lat_last), 32'd2);
    check_eq("fr_conv_low", 32'(conv_low_last), 32'd64);
    check_eq("fr_trig", triggered, 1);
    check_eq("fr_armed", armed, 0);

    // rising trigger at 80
    frames[0] = mk(8'h70); frames[1] = mk(8'h78); frames[2] = mk(8'h80); frames[3] = mk(8'h88);
    frames[4] = mk(8'h90); frames[5] = mk(8'h98); frames[6] = mk(8'hA0); frames[7] = mk(8'hA8);
    do_reset();
    trig_mode = 2'b01;
    trig_level = 8'h80;
    start(c0);
    step(160);
    check_eq("rise_none_yet", 32'(xq_data.size()), 32'd0);
    check_eq("rise_armed", armed, 1);
    check_eq("rise_not_trig", triggered, 0);
    wait_xfers("rise_timeout", 2, 250);
    check_eq("rise_d0", xd(0), 32'h80);
    check_eq("rise_d1", xd(1), 32'h88);
    check_eq("rise_trig", triggered, 1);
    check_eq("rise_armed_off", armed, 0);

    // falling trigger at 40; first sample has no predecessor
    frames[0] = mk(8'h50); frames[1] = mk(8'h3F); frames[2] = mk(8'h30); frames[3] = mk(8'h20);
    do_reset();
    trig_mode = 2'b10;
    trig_level = 8'h40;
    start(c0);
    step(100);
    check_eq("fall_none_yet", 32'(xq_data.size()), 32'd0);
    check_eq("fall_armed", armed, 1);
    wait_xfers("fall_timeout1", 1, 150);
    check_eq("fall_d0", xd(0), 32'h3F);
    wait_xfers("fall_timeout2", 2, 150);
    check_eq("fall_d1", xd(1), 32'h30);

    // decimation by 3
    for (int i = 0; i < 8; i++) frames[i] = mk(8'(i + 1));
    do_reset();
    decim = 8'd2;
    start(c0);
    step(500);
    check_eq("dec_count", 32'(xq_data.size()), 32'd2);
    check_eq("dec_d0", xd(0), 32'h01);
    check_eq("dec_d1", xd(1), 32'h04);
    check_eq("dec_gap", 32'(xc(1) - xc(0)), 32'd228);

    // backpressure, overrun, clear
    for (int i = 0; i < 8; i++) frames[i] = mk(8'(8'h11 * (i + 1)));
    do_reset();
    sample_ready = 1'b0;
    start(c0);
    step(160);
    check_eq("ovr_hold_data", sample_data, 8'h11);
    check_eq("ovr_set", overrun, 1);
    step(170);
    check_eq("ovr_still_valid", sample_valid, 1);
    check_eq("ovr_still_data", sample_data, 8'h11);
    check_eq("ovr_sticky", overrun, 1);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    check_eq("ovr_xfer_data", xd(0), 32'h11);
    check_eq("ovr_valid_drop", sample_valid, 0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("clr_ovr", overrun, 0);
    check_eq("clr_trig", triggered, 0);
    check_eq("clr_armed", armed, 1);
    sample_ready = 1'b1;
    wait_xfers("clr_timeout", 2, 150);
    check_eq("clr_rearm_data", xd(1), 32'h55);

    // enable dropped mid-SHIFT after 7 bits, re-enable, then async reset mid-frame
    for (int i = 0; i < 8; i++) frames[i] = 16'h2A5C;
    do_reset();
    start(c0);
    step(38);
    check_eq("abort_in_shift", adc_conv, 0);
    enable = 1'b0;
    step(1);
    check_eq("abort_conv", adc_conv, 1);
    check_eq("abort_clk", adc_clk, 0);
    check_eq("abort_armed", armed, 0);
    step(100);
    check_eq("abort_no_sample", 32'(xq_data.size()), 32'd0);
    start(c1);
    wait_xfers("reen_timeout", 1, 120);
    check_eq("reen_data", xd(0), 32'hA9);
    check_eq("reen_lat", 32'(xc(0) - c1), 32'd75);
    step(30);
    check_eq("pre_rst_conv", adc_conv, 0);
    check_eq("pre_rst_trig", triggered, 1);
    reset = 1'b1;
    #1;
    check_eq("arst_clk", adc_clk, 0);
    check_eq("arst_conv", adc_conv, 1);
    check_eq("arst_data", sample_data, 0);
    check_eq("arst_valid", sample_valid, 0);
    check_eq("arst_armed", armed, 0);
    check_eq("arst_trig", triggered, 0);
    check_eq("arst_ovr", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
